line_bbox_scanner: RTL and testbench
====================================

# line_bbox_scanner

Sequential line rasterizer. Accepts one line command (two 9-bit endpoints), walks every pixel of the line's bounding box in raster order, and emits each pixel that lies exactly on the line to the downstream pixel writer through a valid/ready handshake. The on-line test is an exact edge-function evaluation, updated incrementally with additions only; there are no per-pixel multiplies. It sits between the command/vertex stage and the framebuffer write stage.

## Interface
- No parameters. Coordinate width is fixed at 9 bits, range 0..511.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-high; clears all state.
- cmd_valid  in  1  a line command is presented.
- cmd_ready  out  1  block is idle and can accept a command.
- x0, y0, x1, y1  in  9 each  endpoints, unsigned; sampled when cmd_valid && cmd_ready.
- pix_valid  out  1  pix_x/pix_y hold an on-line pixel.
- pix_ready  in  1  downstream accepts the pixel.
- pix_x, pix_y  out  9 each  pixel coordinate.
- done  out  1  one-cycle pulse after the last bounding-box cell is processed.

## Operation
- Latched on command: minX/maxX, minY/maxY, dx = x1−x0, dy = y1−y0. dx and dy are 10-bit signed.
- Edge function: E(px,py) = (px−x0)·dy − (py−y0)·dx. E is 21-bit signed and exact, with no wrap: the worst-case magnitude is 522242.
- A cell is on the line iff E == 0. Cells outside the bounding box are never visited.
- Incremental update:
  - x step: E += dy.
  - Row change: Erow −= dx, then E = Erow, px = minX.
  - Erow holds E at (minX, current py).
- States:
  - IDLE: cmd_ready = 1. On handshake, latch the endpoints and go to SETUP.
  - SETUP: one cycle. Compute the bounds, dx, dy, and E = Erow = (minX−x0)·dy − (minY−y0)·dx. This is the only multiply. Set px = minX, py = minY, then go to SCAN.
  - SCAN: one cell per cycle.
    - If E == 0: pix_valid = 1. The cell advances only on pix_ready; otherwise px, py, E and the outputs hold.
    - If E ≠ 0: the cell advances unconditionally.
    - Advance from (maxX, maxY) goes to DONE.
  - DONE: done = 1 for one cycle, then IDLE.
- Degenerate commands:
  - A point (x0 == x1, y0 == y1) emits exactly one pixel.
  - Horizontal and vertical lines emit every bbox cell.
  - Endpoint order does not matter.
- Commands are not queued. cmd_ready = 0 from the acceptance cycle until the cycle after done.

## Timing
- Reset values: cmd_ready = 1, pix_valid = 0, pix_x = pix_y = 0, done = 0, state = IDLE.
- pix_valid, pix_x and pix_y are driven from registers only. There is no combinational path from pix_ready or cmd_valid to any output.
- Cycle numbering: command accepted at edge k → SETUP during cycle k+1 → first SCAN cell during cycle k+2.
- With pix_ready held at 1: W·H SCAN cycles, where W = maxX−minX+1 and H = maxY−minY+1. done is asserted in cycle k+2+W·H.
- Each cycle pix_ready is low while pix_valid is high adds exactly one cycle.
- pix_x and pix_y are stable while pix_valid && !pix_ready.
- pix_ready is ignored when pix_valid = 0.
- Reset asserted mid-SETUP/SCAN/DONE: immediately return to IDLE with the reset output values. No further pixels and no done pulse for the aborted command.
- cmd_valid is ignored outside IDLE.

## Structure
- Package line_pkg:
  - coord_t (logic [8:0]).
  - delta_t (signed [9:0]).
  - edge_t (signed [20:0]).
  - scan_state_t enum {IDLE, SETUP, SCAN, DONE}.
- Sub-module line_edge_setup (combinational):
  - Inputs: endpoints.
  - Outputs: minX, maxX, minY, maxY, dx, dy, initial E.
  - The parent registers these in SETUP.
- Parent holds the FSM, px/py counters, the E/Erow accumulators and the handshake.

## Test plan
- Horizontal line (10,5)-(14,5), pix_ready = 1:
  - pixels (10,5)…(14,5) in order on consecutive cycles.
  - done exactly 5 cycles after the first SCAN cycle.
- Diagonal (3,3)-(0,0):
  - pixels (0,0), (1,1), (2,2), (3,3) only.
  - 16 SCAN cycles.
  - done at k+18.
- Point (7,7): a single pixel (7,7), with done at k+3.
- Backpressure on (0,0)-(2,2): pix_ready low for 3 cycles when (1,1) is presented.
  - (1,1) is held stable for those cycles.
  - No pixel is skipped or duplicated.
  - done is delayed by 3 cycles.
- Width extremes (0,0)-(511,1):
  - exactly two pixels, (0,0) and (511,1).
  - 1024 SCAN cycles.
  - No false zero from E overflow.
- Reset during SCAN of (0,0)-(20,20), mid-bbox:
  - outputs return to reset values asynchronously.
  - cmd_ready = 1 after reset release.
  - A new command (4,4)-(4,6) emits (4,4), (4,5), (4,6) correctly.

Source files
------------

// File: rtl/line_pkg.sv
// Shared types and helpers for the bounding-box line rasterizer.
package line_pkg;

    localparam int unsigned COORD_W = 9;
    localparam int unsigned DELTA_W = 10;
    localparam int unsigned EDGE_W  = 21;

    typedef logic [COORD_W-1:0]        coord_t;
    typedef logic signed [DELTA_W-1:0] delta_t;
    typedef logic signed [EDGE_W-1:0]  edge_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    typedef struct packed {
        coord_t x0;
        coord_t y0;
        coord_t x1;
        coord_t y1;
    } line_cmd_t;

    // Signed difference of two unsigned coordinates; always fits in 10 bits.
    function automatic delta_t coord_diff(input coord_t a, input coord_t b);
        return delta_t'({1'b0, a}) - delta_t'({1'b0, b});
    endfunction

endpackage

// File: rtl/line_edge_setup.sv
// Combinational line setup: bounding box, deltas and the edge value at the top-left bbox corner.
module line_edge_setup
    import line_pkg::*;
(
    input  line_cmd_t           cmd,
    output logic [COORD_W-1:0]  min_x,
    output logic [COORD_W-1:0]  max_x,
    output logic [COORD_W-1:0]  min_y,
    output logic [COORD_W-1:0]  max_y,
    output logic signed [DELTA_W-1:0] dx,
    output logic signed [DELTA_W-1:0] dy,
    output logic signed [EDGE_W-1:0]  e_init
);

    delta_t off_x;
    delta_t off_y;

    always_comb begin
        min_x = (cmd.x0 < cmd.x1) ? cmd.x0 : cmd.x1;
        max_x = (cmd.x0 < cmd.x1) ? cmd.x1 : cmd.x0;
        min_y = (cmd.y0 < cmd.y1) ? cmd.y0 : cmd.y1;
        max_y = (cmd.y0 < cmd.y1) ? cmd.y1 : cmd.y0;
        dx    = coord_diff(cmd.x1, cmd.x0);
        dy    = coord_diff(cmd.y1, cmd.y0);
        off_x = coord_diff(min_x, cmd.x0);
        off_y = coord_diff(min_y, cmd.y0);
        // Magnitudes stay below 2^20, so the 21-bit products are exact.
        e_init = edge_t'(off_x) * edge_t'(dy) - edge_t'(off_y) * edge_t'(dx);
    end

endmodule

// File: rtl/line_bbox_scanner.sv
// Walks a line's bounding box in raster order and emits every cell whose edge function is zero.
module line_bbox_scanner
    import line_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [COORD_W-1:0] x0,
    input  logic [COORD_W-1:0] y0,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               done
);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_SETUP = SETUP;
    localparam logic [1:0] ST_SCAN  = SCAN;
    localparam logic [1:0] ST_DONE  = DONE;

    logic [1:0] state_q, state_d;
    line_cmd_t  cmd_q, cmd_d;
    coord_t     min_x_q, min_x_d, max_x_q, max_x_d, max_y_q, max_y_d;
    delta_t     dx_q, dx_d, dy_q, dy_d;
    edge_t      e_q, e_d, erow_q, erow_d;
    coord_t     pix_x_d, pix_y_d;
    logic       pix_valid_d, cmd_ready_d, done_d;

    coord_t s_min_x, s_max_x, s_min_y, s_max_y;
    delta_t s_dx, s_dy;
    edge_t  s_e;
    edge_t  e_step, e_row;

    line_edge_setup u_setup (
        .cmd    (cmd_q),
        .min_x  (s_min_x),
        .max_x  (s_max_x),
        .min_y  (s_min_y),
        .max_y  (s_max_y),
        .dx     (s_dx),
        .dy     (s_dy),
        .e_init (s_e)
    );

    // Incremental edge values for the next cell in the row and the first cell of the next row.
    assign e_step = e_q + edge_t'(dy_q);
    assign e_row  = erow_q - edge_t'(dx_q);

    always_comb begin
        state_d     = state_q;
        cmd_d       = cmd_q;
        min_x_d     = min_x_q;
        max_x_d     = max_x_q;
        max_y_d     = max_y_q;
        dx_d        = dx_q;
        dy_d        = dy_q;
        e_d         = e_q;
        erow_d      = erow_q;
        pix_x_d     = pix_x;
        pix_y_d     = pix_y;
        pix_valid_d = pix_valid;
        cmd_ready_d = cmd_ready;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid) begin
                    cmd_d       = '{x0: x0, y0: y0, x1: x1, y1: y1};
                    cmd_ready_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                min_x_d     = s_min_x;
                max_x_d     = s_max_x;
                max_y_d     = s_max_y;
                dx_d        = s_dx;
                dy_d        = s_dy;
                e_d         = s_e;
                erow_d      = s_e;
                pix_x_d     = s_min_x;
                pix_y_d     = s_min_y;
                pix_valid_d = (s_e == '0);
                state_d     = ST_SCAN;
            end
            ST_SCAN: begin
                // An on-line cell waits for the writer; off-line cells pass through.
                if (!pix_valid || pix_ready) begin
                    if (pix_x == max_x_q) begin
                        if (pix_y == max_y_q) begin
                            pix_valid_d = 1'b0;
                            done_d      = 1'b1;
                            state_d     = ST_DONE;
                        end else begin
                            erow_d      = e_row;
                            e_d         = e_row;
                            pix_x_d     = min_x_q;
                            pix_y_d     = pix_y + COORD_W'(1);
                            pix_valid_d = (e_row == '0);
                        end
                    end else begin
                        e_d         = e_step;
                        pix_x_d     = pix_x + COORD_W'(1);
                        pix_valid_d = (e_step == '0);
                    end
                end
            end
            default: begin
                cmd_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cmd_q     <= '0;
            min_x_q   <= '0;
            max_x_q   <= '0;
            max_y_q   <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            e_q       <= '0;
            erow_q    <= '0;
            pix_x     <= '0;
            pix_y     <= '0;
            pix_valid <= 1'b0;
            cmd_ready <= 1'b1;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cmd_q     <= cmd_d;
            min_x_q   <= min_x_d;
            max_x_q   <= max_x_d;
            max_y_q   <= max_y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            e_q       <= e_d;
            erow_q    <= erow_d;
            pix_x     <= pix_x_d;
            pix_y     <= pix_y_d;
            pix_valid <= pix_valid_d;
            cmd_ready <= cmd_ready_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_line_bbox_scanner.sv
// Directed bench for line_bbox_scanner: per-cycle comparison against a cross-product pixel model.
module tb_line_bbox_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [8:0] x0, y0, x1, y1;
    logic       pix_valid;
    logic       pix_ready;
    logic [8:0] pix_x, pix_y;
    logic       done;

    int cyc    = 0;
    int errors = 0;
    int checks = 0;
    int log_x[$];
    int log_y[$];
    int lat;

    line_bbox_scanner dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .x0        (x0),
        .y0        (y0),
        .x1        (x1),
        .y1        (y1),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .done      (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got event, expected none", name);
    endtask

    // Issues one command and follows it cycle by cycle. stall_idx selects which emitted pixel
    // is back-pressured for stall_len cycles; abort_at > 0 leaves the scan early.
    task automatic run_cmd(input int ax0, input int ay0, input int ax1, input int ay1,
                           input int stall_idx, input int stall_len, input int abort_at,
                           output int latency);
        int ex[$];
        int ey[$];
        int minx, maxx, miny, maxy, w, h, acc, stalls, idx, srem, n, budget;
        bit fin;
        minx = (ax0 < ax1) ? ax0 : ax1;
        maxx = (ax0 < ax1) ? ax1 : ax0;
        miny = (ay0 < ay1) ? ay0 : ay1;
        maxy = (ay0 < ay1) ? ay1 : ay0;
        w = maxx - minx + 1;
        h = maxy - miny + 1;
        for (int py = miny; py <= maxy; py++)
            for (int px = minx; px <= maxx; px++)
                if ((px - ax0) * (ay1 - ay0) == (py - ay0) * (ax1 - ax0)) begin
                    ex.push_back(px);
                    ey.push_back(py);
                end
        log_x.delete();
        log_y.delete();
        latency = -1;

        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_ready_before_cmd", int'(cmd_ready), 1);
        x0 = 9'(ax0); y0 = 9'(ay0); x1 = 9'(ax1); y1 = 9'(ay1);
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        acc = cyc;
        check("setup_pix_valid", int'(pix_valid), 0);
        check("setup_cmd_ready", int'(cmd_ready), 0);

        idx = 0; srem = stall_len; stalls = 0; fin = 1'b0;
        budget = w * h + stall_len + 10;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (abort_at > 0 && c == abort_at) begin
                fin = 1'b1;
                latency = -2;
                break;
            end
            if (cmd_ready !== 1'b0) fail_now("cmd_ready_during_scan");
            if (pix_valid === 1'b1) begin
                if (ex.size() == 0) begin
                    fail_now("extra_pixel");
                    pix_ready = 1'b1;
                end else begin
                    check("pix_x", int'(pix_x), ex[0]);
                    check("pix_y", int'(pix_y), ey[0]);
                    if (idx == stall_idx && srem > 0) begin
                        pix_ready = 1'b0;
                        srem--;
                        stalls++;
                    end else begin
                        pix_ready = 1'b1;
                        log_x.push_back(int'(pix_x));
                        log_y.push_back(int'(pix_y));
                        void'(ex.pop_front());
                        void'(ey.pop_front());
                        idx++;
                    end
                end
            end else begin
                pix_ready = (cyc % 3 != 0);
            end
            if (done === 1'b1) begin
                latency = cyc + 1 - acc;
                check("done_latency", latency, 2 + w * h + stalls);
                check("missing_pixels", ex.size(), 0);
                fin = 1'b1;
                break;
            end
        end
        pix_ready = 1'b1;
        if (!fin) begin
            fail_now("timeout_waiting_done");
        end else if (latency != -2) begin
            @(negedge clk);
            check("done_one_cycle", int'(done), 0);
            check("cmd_ready_after_done", int'(cmd_ready), 1);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0;
        pix_ready = 1'b1;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0;
        #2;
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_pix_x", int'(pix_x), 0);
        check("rst_pix_y", int'(pix_y), 0);
        check("rst_done", int'(done), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Horizontal line
        run_cmd(10, 5, 14, 5, -1, 0, 0, lat);
        check("horiz_latency", lat, 7);
        check("horiz_count", log_x.size(), 5);
        for (int i = 0; i < log_x.size(); i++) begin
            check("horiz_x", log_x[i], 10 + i);
            check("horiz_y", log_y[i], 5);
        end

        // Diagonal with reversed endpoints
        run_cmd(3, 3, 0, 0, -1, 0, 0, lat);
        check("diag_latency", lat, 18);
        check("diag_count", log_x.size(), 4);
        for (int i = 0; i < log_x.size(); i++) begin
            check("diag_x", log_x[i], i);
            check("diag_y", log_y[i], i);
        end

        // Single point
        run_cmd(7, 7, 7, 7, -1, 0, 0, lat);
        check("point_latency", lat, 3);
        check("point_count", log_x.size(), 1);
        if (log_x.size() == 1) begin
            check("point_x", log_x[0], 7);
            check("point_y", log_y[0], 7);
        end

        // Backpressure on the second pixel
        run_cmd(0, 0, 2, 2, 1, 3, 0, lat);
        check("bp_latency", lat, 14);
        check("bp_count", log_x.size(), 3);
        for (int i = 0; i < log_x.size(); i++) begin
            check("bp_x", log_x[i], i);
            check("bp_y", log_y[i], i);
        end

        // Full-width bounding box
        run_cmd(0, 0, 511, 1, -1, 0, 0, lat);
        check("wide_latency", lat, 1026);
        check("wide_count", log_x.size(), 2);
        if (log_x.size() == 2) begin
            check("wide_x0", log_x[0], 0);
            check("wide_y0", log_y[0], 0);
            check("wide_x1", log_x[1], 511);
            check("wide_y1", log_y[1], 1);
        end

        // Reset in the middle of a scan
        run_cmd(0, 0, 20, 20, -1, 0, 60, lat);
        #2 rst = 1'b1;
        #1;
        check("abort_cmd_ready", int'(cmd_ready), 1);
        check("abort_pix_valid", int'(pix_valid), 0);
        check("abort_pix_x", int'(pix_x), 0);
        check("abort_pix_y", int'(pix_y), 0);
        check("abort_done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_abort_cmd_ready", int'(cmd_ready), 1);
            if (pix_valid !== 1'b0) fail_now("post_abort_pixel");
            if (done !== 1'b0) fail_now("post_abort_done");
        end

        // Vertical line after reset
        run_cmd(4, 4, 4, 6, -1, 0, 0, lat);
        check("vert_latency", lat, 5);
        check("vert_count", log_x.size(), 3);
        for (int i = 0; i < log_x.size(); i++) begin
            check("vert_x", log_x[i], 4);
            check("vert_y", log_y[i], 4 + i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
